// File: rtl/round_robin_arbiter_8_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
// master drives requests and done; slave returns the registered grant.
interface round_robin_arbiter_8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/round_robin_arbiter_8.sv
// 8-way round-robin arbiter with registered one-hot grant,
// bounded hold time and a forced-release timeout pulse.
module round_robin_arbiter_8 #(
    parameter int MAX_HOLD = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    round_robin_arbiter_8_if.slave bus
);
    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] last;
    logic [2:0] last_nxt;
    logic [4:0] hcnt;
    logic [4:0] hcnt_nxt;
    logic [7:0] gnt;
    logic [7:0] gnt_nxt;
    logic [2:0] idx;
    logic [2:0] idx_nxt;
    logic       valid;
    logic       valid_nxt;
    logic       tmo;
    logic       tmo_nxt;

    logic [2:0] winner;
    logic [2:0] cand;
    logic       hit;
    logic       rel;
    logic       expire;

    // Scan starts one past the last owner and wraps 7 -> 0.
    always_comb begin
        winner = '0;
        hit    = 1'b0;
        cand   = '0;
        for (int i = 1; i <= 8; i++) begin
            cand = last + 3'(i);
            if (!hit && bus.req[cand]) begin
                hit    = 1'b1;
                winner = cand;
            end
        end
    end

    assign rel    = bus.done || !bus.req[idx];
    assign expire = (hcnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 3'd7;
            hcnt  <= '0;
            gnt   <= '0;
            idx   <= '0;
            valid <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            hcnt  <= hcnt_nxt;
            gnt   <= gnt_nxt;
            idx   <= idx_nxt;
            valid <= valid_nxt;
            tmo   <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = GRANT;
            GRANT:   if (rel || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        last_nxt  = last;
        hcnt_nxt  = hcnt;
        gnt_nxt   = gnt;
        idx_nxt   = idx;
        valid_nxt = valid;
        tmo_nxt   = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt   = '0;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
                hcnt_nxt  = '0;
                if (hit) begin
                    gnt_nxt   = 8'b1 << winner;
                    idx_nxt   = winner;
                    valid_nxt = 1'b1;
                    last_nxt  = winner;
                end
            end
            GRANT: begin
                // A voluntary release wins over an expiring hold.
                unique case (1'b1)
                    rel: begin
                        gnt_nxt   = '0;
                        idx_nxt   = '0;
                        valid_nxt = 1'b0;
                        hcnt_nxt  = '0;
                    end
                    (expire && !rel): begin
                        gnt_nxt   = '0;
                        idx_nxt   = '0;
                        valid_nxt = 1'b0;
                        hcnt_nxt  = '0;
                        tmo_nxt   = 1'b1;
                    end
                    default: hcnt_nxt = hcnt + 5'd1;
                endcase
            end
            default: begin
                gnt_nxt   = '0;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
                hcnt_nxt  = '0;
            end
        endcase
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_idx   = idx;
    assign bus.gnt_valid = valid;
    assign bus.timeout   = tmo;
endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Directed bench for round_robin_arbiter_8: a per-cycle vector
// table plus hand-written rotation, timeout and reset sequences.
module tb_round_robin_arbiter_8;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    round_robin_arbiter_8_if bus ();

    round_robin_arbiter_8 #(
        .MAX_HOLD(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t tbl[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] eg,
                         input logic [2:0] ei, input logic ev,
                         input logic et);
        vectors++;
        if (bus.gnt !== eg || bus.gnt_idx !== ei ||
            bus.gnt_valid !== ev || bus.timeout !== et) begin
            miscompares++;
            $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
                     name, bus.gnt, bus.gnt_idx, bus.gnt_valid,
                     bus.timeout, eg, ei, ev, et);
        end
    endtask

    task automatic step(input string name, input logic [7:0] r,
                        input logic d, input logic [7:0] eg,
                        input logic [2:0] ei, input logic ev,
                        input logic et);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        #1;
        check(name, eg, ei, ev, et);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        #12;
        check("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        tbl[0]  = '{8'h84, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[1]  = '{8'h84, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{8'h84, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[3]  = '{8'h84, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[4]  = '{8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[8]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[10] = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[11] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[12] = '{8'h28, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{8'h28, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[14] = '{8'h28, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        do_reset();
        foreach (tbl[k]) begin
            step($sformatf("table[%0d]", k), tbl[k].req, tbl[k].done,
                 tbl[k].gnt, tbl[k].idx, tbl[k].valid, tbl[k].tmo);
        end

        // Full rotation with done one cycle after each grant.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step($sformatf("rot_grant[%0d]", k), 8'hFF, 1'b0,
                 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            step($sformatf("rot_dead[%0d]", k), 8'hFF, 1'b1,
                 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Hold to expiry, timeout pulse, dead cycle, re-grant.
        do_reset();
        step("hold_grant", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) begin
            step($sformatf("hold[%0d]", k), 8'h08, 1'b0,
                 8'h08, 3'd3, 1'b1, 1'b0);
        end
        step("hold_timeout", 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        step("hold_regrant", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        step("regrant_release", 8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

        // Timed-out owner loses to another requester in rotation.
        step("tmo2_grant", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) begin
            step($sformatf("tmo2_hold[%0d]", k), 8'h08, 1'b0,
                 8'h08, 3'd3, 1'b1, 1'b0);
        end
        step("tmo2_timeout", 8'h0C, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        step("tmo2_other", 8'h0C, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
        step("tmo2_release", 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

        // done coincides with the last hold cycle: no timeout.
        step("race_grant", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) begin
            step($sformatf("race_hold[%0d]", k), 8'h08, 1'b0,
                 8'h08, 3'd3, 1'b1, 1'b0);
        end
        step("race_release", 8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step("mid_grant", 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/round_robin_arbiter_8.md
ROUND_ROBIN_ARBITER_8 -- requirements
Module: round_robin_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles per ownership; legal range 1..16.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  request vector; bit i = requester i wants the shared 8-to-3 encoder path.
REQ-005 Port: done  input  1  owner finished; sampled only in GRANT.
REQ-006 Port: gnt  output  8  one-hot grant, registered.
REQ-007 Port: gnt_idx  output  3  binary index of granted requester, registered.
REQ-008 Port: gnt_valid  output  1  high while a grant is held.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-010 Two states: IDLE, GRANT; internal 3-bit priority pointer last; 5-bit hold counter hcnt.
REQ-011 IDLE, req == 0: remain IDLE, outputs stay zero.
REQ-012 IDLE, req != 0 at edge N: winner = first set bit scanning (last+1) mod 8 upward with wrap 7->0; after edge N gnt = one-hot(winner), gnt_idx = winner, gnt_valid = 1, last = winner, hcnt = 0, state GRANT.
REQ-013 Grant latency: exactly one clock from sampled req to visible gnt; no combinational path req->gnt.
REQ-014 GRANT, done == 1 or req[gnt_idx] == 0: release at next edge -> gnt = 0, gnt_idx = 0, gnt_valid = 0, state IDLE, timeout = 0.
REQ-015 GRANT, no release, hcnt == MAX_HOLD-1: forced release as REQ-014 plus timeout = 1 for that one cycle.
REQ-016 GRANT, otherwise: hold gnt/gnt_idx unchanged, hcnt increments.
REQ-017 done and timeout condition in same cycle: normal release, timeout stays 0.
REQ-018 Grant hold length: at most MAX_HOLD cycles of gnt_valid = 1 per ownership.
REQ-019 Mandatory one dead cycle (IDLE, gnt_valid = 0) between any two grants, including re-grant of the same requester.
REQ-020 Requests from non-owners during GRANT are ignored; not latched; only req at IDLE arbitration edge matters.
REQ-021 Timed-out requester still requesting remains eligible; it wins again only if no other requester is set between it and itself in the rotation.
REQ-022 done in IDLE ignored.
REQ-023 gnt is always zero or exactly one-hot; gnt_valid == |gnt; gnt_idx == encode(gnt).
REQ-024 timeout never high in two consecutive cycles.

Reset
REQ-025 rst_n low: immediately (no clock) gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0, state IDLE, hcnt = 0, last = 7 (requester 0 has top priority first).
REQ-026 Reset asserted mid-grant aborts the grant with no timeout pulse; first arbitration after rst_n release uses last = 7.
REQ-027 rst_n deassertion is synchronised externally; block samples inputs from first rising edge with rst_n high.

Verification
REQ-028 After reset, req = 8'hFF held, done pulsed 1 cycle after each grant -> grant order 0,1,2,...,7,0 with one dead cycle between grants.
REQ-029 req = 8'b1000_0100, last = 7 -> gnt = 8'h04, gnt_idx = 2 one cycle later; release via done; next grant gnt = 8'h80, gnt_idx = 7.
REQ-030 MAX_HOLD = 8, req[3] held, done = 0 -> gnt_valid high exactly 8 cycles, timeout = 1 on release cycle, dead cycle, re-grant to 3.
REQ-031 Owner 5 drops req[5] while granted, done = 0 -> gnt = 0, gnt_valid = 0 next edge, timeout = 0.
REQ-032 done = 1 on same cycle hcnt reaches MAX_HOLD-1 -> release, timeout stays 0.
REQ-033 rst_n pulled low while gnt = 8'h10 between edges -> outputs zero immediately; after release req = 8'hFF -> gnt = 8'h01.
